// File: rtl/axi_arbiter.sv
// rtl/axi_arbiter.sv - icache/dcache to single AXI master port arbiter
//
// Purpose: merges an icache read port and a dcache read/write port onto one
// AXI master. Reads and writes run in two independent FSMs. Read grants
// favour dcache, with a fairness counter that hands icache the bus after two
// consecutive dcache grants while icache was waiting. A dcache read that
// targets the 16-byte line of an in-flight (or just-accepted) write is held
// off until the write response completes.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_ar*/i_r*                    icache read address / read data
//   d_ar*/d_r*                    dcache read address / read data
//   d_aw*/d_w*/d_b*               dcache write address / data / response
//   ar*/r*                        AXI read address / read data channels
//   aw*/w*/b*                     AXI write address / data / response channels
module axi_arbiter #(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // icache read
  input  logic        i_arvalid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  output logic        i_arready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        i_rready,
  // dcache read
  input  logic        d_arvalid,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  output logic        d_arready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  input  logic        d_rready,
  // dcache write
  input  logic        d_awvalid,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  output logic        d_awready,
  input  logic        d_wvalid,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  // AXI read
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic [3:0]  rid,
  // AXI write
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [3:0]  awid,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  rd_state_t   rd_state, rd_next;
  wr_state_t   wr_state, wr_next;

  logic [31:0] rd_addr_q;
  logic [7:0]  rd_len_q;
  logic [2:0]  rd_size_q;
  logic        rd_owner_d_q;   // 1: current read belongs to dcache
  logic [1:0]  fair_cnt;

  logic [31:0] wr_addr_q;
  logic [7:0]  wr_len_q;
  logic [2:0]  wr_size_q;

  logic        aw_accept;
  logic        d_hazard;
  logic        force_i;
  logic        grant_d;
  logic        grant_i;
  logic        sel_rready;
  logic        rid_unused;

  // Responses are routed by owner state, so rid carries no information here.
  assign rid_unused = ^rid;

  // ---------------------------------------------------------------------
  // Read grant
  // ---------------------------------------------------------------------
  assign aw_accept = (wr_state == WR_IDLE) && !rst && d_awvalid;

  // A dcache read to a line still being written (or being accepted this
  // cycle) could return stale data, so it waits for the write to finish.
  assign d_hazard = ((wr_state != WR_IDLE) && (d_araddr[31:4] == wr_addr_q[31:4])) ||
                    (aw_accept && (d_araddr[31:4] == d_awaddr[31:4]));

  assign force_i = (fair_cnt == 2'd2) && i_arvalid;
  assign grant_d = (rd_state == RD_IDLE) && !rst && d_arvalid && !d_hazard && !force_i;
  assign grant_i = (rd_state == RD_IDLE) && !rst && i_arvalid && !grant_d;

  // ---------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state     <= RD_IDLE;
      rd_addr_q    <= '0;
      rd_len_q     <= '0;
      rd_size_q    <= '0;
      rd_owner_d_q <= 1'b0;
      fair_cnt     <= 2'd0;
    end else begin
      rd_state <= rd_next;
      if (grant_d) begin
        rd_addr_q    <= d_araddr;
        rd_len_q     <= d_arlen;
        rd_size_q    <= d_arsize;
        rd_owner_d_q <= 1'b1;
      end else if (grant_i) begin
        rd_addr_q    <= i_araddr;
        rd_len_q     <= i_arlen;
        rd_size_q    <= i_arsize;
        rd_owner_d_q <= 1'b0;
      end
      // Counts dcache grants that overtook a waiting icache request.
      if (!i_arvalid || grant_i)
        fair_cnt <= 2'd0;
      else if (grant_d && (fair_cnt != 2'd2))
        fair_cnt <= fair_cnt + 2'd1;
    end
  end

  assign sel_rready = rd_owner_d_q ? d_rready : i_rready;

  always_comb begin
    rd_next   = rd_state;
    i_arready = 1'b0;
    d_arready = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    i_rvalid  = 1'b0;
    i_rdata   = '0;
    i_rlast   = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_rlast   = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        i_arready = grant_i;
        d_arready = grant_d;
        if (grant_i || grant_d)
          rd_next = RD_ADDR;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready)
          rd_next = RD_DATA;
      end
      RD_DATA: begin
        rready = sel_rready;
        if (rd_owner_d_q) begin
          d_rvalid = rvalid;
          d_rdata  = rdata;
          d_rlast  = rlast;
        end else begin
          i_rvalid = rvalid;
          i_rdata  = rdata;
          i_rlast  = rlast;
        end
        if (rvalid && sel_rready && rlast)
          rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  assign araddr  = rd_addr_q;
  assign arlen   = rd_len_q;
  assign arsize  = rd_size_q;
  assign arburst = 2'b01;
  assign arid    = rd_owner_d_q ? D_ID : I_ID;

  // ---------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state  <= WR_IDLE;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      wr_size_q <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_accept) begin
        wr_addr_q <= d_awaddr;
        wr_len_q  <= d_awlen;
        wr_size_q <= d_awsize;
      end
    end
  end

  always_comb begin
    wr_next   = wr_state;
    d_awready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wdata     = '0;
    wstrb     = '0;
    wlast     = 1'b0;
    d_wready  = 1'b0;
    d_bvalid  = 1'b0;
    bready    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        d_awready = !rst;
        if (aw_accept)
          wr_next = WR_ADDR;
      end
      WR_ADDR: begin
        awvalid = 1'b1;
        if (awready)
          wr_next = WR_DATA;
      end
      WR_DATA: begin
        wvalid   = d_wvalid;
        wdata    = d_wdata;
        wstrb    = d_wstrb;
        wlast    = d_wlast;
        d_wready = wready;
        if (d_wvalid && wready && d_wlast)
          wr_next = WR_RESP;
      end
      WR_RESP: begin
        d_bvalid = bvalid;
        bready   = d_bready;
        if (bvalid && d_bready)
          wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  assign awaddr  = wr_addr_q;
  assign awlen   = wr_len_q;
  assign awsize  = wr_size_q;
  assign awburst = 2'b01;
  assign awid    = D_ID;

endmodule

// File: tb/tb_axi_arbiter.sv
// tb/tb_axi_arbiter.sv - self-checking bench for axi_arbiter
module tb_axi_arbiter;

  localparam logic [3:0] IID = 4'd0;
  localparam logic [3:0] DID = 4'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic [2:0]  i_arsize;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic [2:0]  d_arsize;
  logic        d_awvalid, d_awready, d_wvalid, d_wlast, d_wready, d_bvalid, d_bready;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [2:0]  d_awsize;
  logic [3:0]  d_wstrb;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid, rid;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awid, wstrb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_arbiter #(.I_ID(IID), .D_ID(DID)) dut (
    .clk(clk), .rst(rst),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
    .i_arready(i_arready), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast),
    .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .d_rready(d_rready),
    .d_awvalid(d_awvalid), .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize),
    .d_awready(d_awready), .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_wlast(d_wlast), .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arid(arid), .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awid(awid), .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    string       name;
    logic        i_arv;
    logic        d_arv;
    logic [31:0] d_addr;
    logic        d_awv;
    logic [31:0] d_awa;
    logic        exp_i_rdy;
    logic        exp_d_rdy;
  } grant_vec_t;

  grant_vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Acts as the AXI slave for one read: waits for arvalid, accepts it in one
  // cycle, then returns nbeats data beats and checks routing to the owner.
  task automatic serve_read(input string nm, input logic [3:0] exp_id,
                            input logic [31:0] exp_addr, input int nbeats, input bit to_d);
    int t;
    logic [31:0] beat_data;
    t = 0;
    while (arvalid !== 1'b1 && t < 20) begin
      cyc();
      t++;
    end
    chk({nm, "_arvalid"}, arvalid, 1);
    chk({nm, "_arid"}, arid, exp_id);
    chk({nm, "_araddr"}, araddr, exp_addr);
    chk({nm, "_arlen"}, arlen, nbeats - 1);
    chk({nm, "_arburst"}, arburst, 1);
    arready = 1'b1;
    cyc();
    arready = 1'b0;
    #1;
    chk({nm, "_arvalid_drop"}, arvalid, 0);
    for (int b = 0; b < nbeats; b++) begin
      beat_data = exp_addr ^ (32'h55 << b);
      rvalid = 1'b1;
      rdata  = beat_data;
      rlast  = (b == nbeats - 1);
      rid    = exp_id;
      #1;
      chk({nm, "_rready"}, rready, 1);
      chk({nm, "_own_rvalid"}, to_d ? d_rvalid : i_rvalid, 1);
      chk({nm, "_other_rvalid"}, to_d ? i_rvalid : d_rvalid, 0);
      chk({nm, "_rdata"}, to_d ? d_rdata : i_rdata, beat_data);
      chk({nm, "_rlast"}, to_d ? d_rlast : i_rlast, (b == nbeats - 1));
      cyc();
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs, wlast_beat, t, b;
    bit tog;

    vecs[0] = '{"idle_none",   0, 0, 32'h0,    0, 32'h0,    0, 0};
    vecs[1] = '{"i_only",      1, 0, 32'h0,    0, 32'h0,    1, 0};
    vecs[2] = '{"d_only",      0, 1, 32'h100,  0, 32'h0,    0, 1};
    vecs[3] = '{"both_d_wins", 1, 1, 32'h100,  0, 32'h0,    0, 1};
    vecs[4] = '{"aw_hazard",   0, 1, 32'h5000, 1, 32'h5008, 0, 0};
    vecs[5] = '{"aw_haz_i",    1, 1, 32'h5000, 1, 32'h5008, 1, 0};
    vecs[6] = '{"aw_diffline", 0, 1, 32'h5010, 1, 32'h5000, 0, 1};

    rst = 1'b1;
    i_arvalid = 0; i_araddr = 0; i_arlen = 0; i_arsize = 0; i_rready = 1;
    d_arvalid = 0; d_araddr = 0; d_arlen = 0; d_arsize = 0; d_rready = 1;
    d_awvalid = 0; d_awaddr = 0; d_awlen = 0; d_awsize = 0;
    d_wvalid = 0; d_wdata = 0; d_wstrb = 0; d_wlast = 0; d_bready = 0;
    arready = 0; rvalid = 0; rdata = 0; rlast = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0;

    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_d_wready", d_wready, 0);
    chk("rst_d_awready", d_awready, 1);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_awburst", awburst, 1);
    chk("rst_awid", awid, DID);

    // Combinational grant decisions with both FSMs idle; inputs withdrawn
    // before the next rising edge so no handshake takes place.
    foreach (vecs[k]) begin
      cyc();
      i_arvalid = vecs[k].i_arv;
      d_arvalid = vecs[k].d_arv;
      d_araddr  = vecs[k].d_addr;
      d_awvalid = vecs[k].d_awv;
      d_awaddr  = vecs[k].d_awa;
      #1;
      chk({vecs[k].name, "_i_arready"}, i_arready, vecs[k].exp_i_rdy);
      chk({vecs[k].name, "_d_arready"}, d_arready, vecs[k].exp_d_rdy);
      i_arvalid = 0; d_arvalid = 0; d_awvalid = 0;
    end

    // Single icache read of four beats
    cyc();
    i_arvalid = 1; i_araddr = 32'h1C000010; i_arlen = 8'd3; i_arsize = 3'd2;
    #1;
    chk("icache_i_arready", i_arready, 1);
    chk("icache_d_arready", d_arready, 0);
    cyc();
    i_arvalid = 0;
    serve_read("icache_rd", IID, 32'h1C000010, 4, 1'b0);
    #1;
    chk("icache_done_rready", rready, 0);

    // Fairness: d, d, then i
    cyc();
    i_arvalid = 1; i_araddr = 32'h400; i_arlen = 0;
    d_arvalid = 1; d_araddr = 32'h800; d_arlen = 0;
    #1;
    chk("fair_g1_d_arready", d_arready, 1);
    chk("fair_g1_i_arready", i_arready, 0);
    cyc();
    serve_read("fair_g1", DID, 32'h800, 1, 1'b1);
    #1;
    chk("fair_turnaround", d_arready, 1);
    cyc();
    serve_read("fair_g2", DID, 32'h800, 1, 1'b1);
    #1;
    chk("fair_g3_i_arready", i_arready, 1);
    chk("fair_g3_d_arready", d_arready, 0);
    cyc();
    i_arvalid = 0; d_arvalid = 0;
    serve_read("fair_g3", IID, 32'h400, 1, 1'b0);

    // Write/read hazard on the same 16-byte line
    cyc();
    d_awvalid = 1; d_awaddr = 32'h00001230; d_awlen = 8'd3; d_awsize = 3'd2;
    #1;
    chk("haz_d_awready", d_awready, 1);
    cyc();
    d_awvalid = 0;
    chk("haz_awvalid", awvalid, 1);
    chk("haz_awaddr", awaddr, 32'h00001230);
    chk("haz_awlen", awlen, 3);
    awready = 1;
    cyc();
    awready = 0;
    d_arvalid = 1; d_araddr = 32'h0000123C; d_arlen = 0;
    #1;
    chk("haz_blocked_data", d_arready, 0);
    wready = 1;
    for (int k = 0; k < 4; k++) begin
      d_wvalid = 1; d_wdata = 32'hB0 + k; d_wstrb = 4'hF; d_wlast = (k == 3);
      #1;
      chk("haz_blocked_beat", d_arready, 0);
      chk("haz_wvalid", wvalid, 1);
      cyc();
    end
    d_wvalid = 0; d_wlast = 0; wready = 0;
    #1;
    chk("haz_blocked_resp", d_arready, 0);
    bvalid = 1; d_bready = 1;
    #1;
    chk("haz_d_bvalid", d_bvalid, 1);
    chk("haz_bready", bready, 1);
    chk("haz_blocked_bhs", d_arready, 0);
    cyc();
    bvalid = 0; d_bready = 0;
    #1;
    chk("haz_granted_after_b", d_arready, 1);
    cyc();
    d_arvalid = 0;
    serve_read("haz_rd", DID, 32'h0000123C, 1, 1'b1);

    // Second write with toggling wready; unrelated read granted mid-write
    cyc();
    d_awvalid = 1; d_awaddr = 32'h00001230; d_awlen = 8'd3;
    cyc();
    d_awvalid = 0;
    awready = 1;
    cyc();
    awready = 0;
    d_arvalid = 1; d_araddr = 32'h00002000; d_arlen = 0;
    #1;
    chk("nohaz_granted", d_arready, 1);
    cyc();
    d_arvalid = 0;
    hs = 0; wlast_beat = -1; t = 0; b = 0; tog = 1'b1;
    while (b < 4 && t < 40) begin
      wready = tog;
      tog = !tog;
      d_wvalid = 1; d_wdata = 32'hA0 + b; d_wstrb = 4'h5; d_wlast = (b == 3);
      #1;
      chk("tog_d_wready", d_wready, wready);
      if (wvalid && wready) begin
        chk("tog_wdata", wdata, 32'hA0 + b);
        chk("tog_wstrb", wstrb, 4'h5);
        if (wlast) wlast_beat = hs;
        hs++;
        b++;
      end
      cyc();
      t++;
    end
    d_wvalid = 0; d_wlast = 0; wready = 1;
    #1;
    chk("tog_w_handshakes", hs, 4);
    chk("tog_wlast_beat", wlast_beat, 3);
    chk("tog_resp_wvalid", wvalid, 0);
    chk("tog_resp_d_wready", d_wready, 0);
    wready = 0;
    bvalid = 1; d_bready = 1;
    #1;
    chk("tog_bready", bready, 1);
    cyc();
    bvalid = 0; d_bready = 0;
    #1;
    chk("tog_wr_idle", d_awready, 1);
    chk("tog_bready_idle", bready, 0);
    serve_read("nohaz_rd", DID, 32'h00002000, 1, 1'b1);

    // Reset during the second beat of a read burst
    cyc();
    i_arvalid = 1; i_araddr = 32'h3000; i_arlen = 8'd3;
    cyc();
    i_arvalid = 0;
    chk("rstmid_arvalid", arvalid, 1);
    arready = 1;
    cyc();
    arready = 0;
    rvalid = 1; rdata = 32'h1; rlast = 0;
    cyc();
    rdata = 32'h2;
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("rstmid_arvalid_0", arvalid, 0);
    chk("rstmid_rready_0", rready, 0);
    chk("rstmid_i_rvalid_0", i_rvalid, 0);
    chk("rstmid_d_rvalid_0", d_rvalid, 0);
    chk("rstmid_araddr_0", araddr, 0);
    rvalid = 0;
    i_arvalid = 1; i_araddr = 32'h4000; i_arlen = 0;
    #1;
    chk("rstmid_new_grant", i_arready, 1);
    cyc();
    i_arvalid = 0;
    serve_read("rstmid_rd", IID, 32'h4000, 1, 1'b0);

    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
